// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation engine.
package rsa_pkg;

  localparam int unsigned N_BIT_DEF = 12;
  localparam int unsigned E_BIT_DEF = 12;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_X,
    PRE_A,
    SQR,
    MUL,
    POST,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_SUB
  } mm_phase_t;

endpackage

// File: rtl/rsa_modexp_mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: r = a*b*2^-N_BIT mod n, fully reduced.
// Iteration 0 runs on the start edge, so done pulses N_BIT+1 cycles after start.
module mont_mul
  import rsa_pkg::*;
#(
  parameter int unsigned N_BIT = N_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic [N_BIT-1:0] n,
  output logic             done,
  output logic [N_BIT-1:0] r
);

  localparam int unsigned W  = N_BIT + 2;
  localparam int unsigned CW = $clog2(N_BIT + 1);

  mm_phase_t        phase, phase_nx;
  logic [W-1:0]     u, b_q, n_q;
  logic [N_BIT-1:0] a_sh;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic [W-1:0]     b_cur, n_cur, u_cur, sum, u_step, u_sub;

  // One reduction step; while idle it works straight from the input ports.
  always_comb begin
    a_bit = a_sh[0];
    b_cur = b_q;
    n_cur = n_q;
    u_cur = u;
    if (phase == MM_IDLE) begin
      a_bit = a[0];
      b_cur = W'(b);
      n_cur = W'(n);
      u_cur = '0;
    end
    sum = u_cur + (a_bit ? b_cur : '0);
    if (sum[0]) sum = sum + n_cur;
    u_step = sum >> 1;
    u_sub  = (u >= n_q) ? (u - n_q) : u;
  end

  always_comb begin
    phase_nx = phase;
    case (phase)
      MM_IDLE: if (start) phase_nx = MM_RUN;
      MM_RUN:  if (cnt == CW'(N_BIT - 1)) phase_nx = MM_SUB;
      MM_SUB:  phase_nx = MM_IDLE;
      default: phase_nx = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) phase <= MM_IDLE;
    else     phase <= phase_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u    <= '0;
      b_q  <= '0;
      n_q  <= '0;
      a_sh <= '0;
      cnt  <= '0;
      r    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        MM_IDLE: if (start) begin
          u    <= u_step;
          a_sh <= a >> 1;
          b_q  <= W'(b);
          n_q  <= W'(n);
          cnt  <= CW'(1);
        end
        MM_RUN: begin
          u    <= u_step;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        MM_SUB: begin
          r    <= N_BIT'(u_sub);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// RSA modular exponentiation (left-to-right square-and-multiply) in the Montgomery
// domain, sharing a single bit-serial Montgomery multiplier across all phases.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int unsigned N_BIT = N_BIT_DEF,
  parameter int unsigned E_BIT = E_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] in_data,
  input  logic             in_mode,
  input  logic [N_BIT-1:0] key_n,
  input  logic [E_BIT-1:0] key_e,
  input  logic [E_BIT-1:0] key_d,
  input  logic [N_BIT-1:0] key_r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned IDX_W = (E_BIT > 1) ? $clog2(E_BIT) : 1;

  state_t           state, state_nx;
  logic [N_BIT-1:0] x_q, n_q, r2_q, xm_q, acc_q;
  logic [E_BIT-1:0] exp_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q, mm_busy;

  logic             accept_c, reject_c, last_c, op_c, mm_start_c, mm_done;
  logic [N_BIT-1:0] mm_a_c, mm_b_c, mm_r;

  assign accept_c   = in_valid & in_ready;
  assign reject_c   = ~key_n[0] | (key_n < N_BIT'(3)) | (in_data >= key_n);
  assign last_c     = (idx_q == '0);
  assign op_c       = state inside {PRE_X, PRE_A, SQR, MUL, POST};
  assign mm_start_c = op_c & ~mm_busy & ~err_q;

  // Operand routing for the shared multiplier.
  always_comb begin
    mm_a_c = '0;
    mm_b_c = '0;
    case (state)
      PRE_X: begin mm_a_c = x_q;           mm_b_c = r2_q;          end
      PRE_A: begin mm_a_c = N_BIT'(1);     mm_b_c = r2_q;          end
      SQR:   begin mm_a_c = acc_q;         mm_b_c = acc_q;         end
      MUL:   begin mm_a_c = acc_q;         mm_b_c = xm_q;          end
      POST:  begin mm_a_c = acc_q;         mm_b_c = N_BIT'(1);     end
      default: ;
    endcase
  end

  mont_mul #(.N_BIT(N_BIT)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start_c),
    .a     (mm_a_c),
    .b     (mm_b_c),
    .n     (n_q),
    .done  (mm_done),
    .r     (mm_r)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept_c) state_nx = PRE_X;
      PRE_X: begin
        if (err_q)        state_nx = HOLD;
        else if (mm_done) state_nx = PRE_A;
      end
      PRE_A: if (mm_done) state_nx = SQR;
      SQR:   if (mm_done) begin
        if (exp_q[idx_q]) state_nx = MUL;
        else if (last_c)  state_nx = POST;
        else              state_nx = SQR;
      end
      MUL:   if (mm_done) state_nx = last_c ? POST : SQR;
      POST:  if (mm_done) state_nx = HOLD;
      HOLD:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      n_q       <= '0;
      r2_q      <= '0;
      xm_q      <= '0;
      acc_q     <= '0;
      exp_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      mm_busy   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      if (mm_start_c)   mm_busy <= 1'b1;
      else if (mm_done) mm_busy <= 1'b0;

      case (state)
        IDLE: if (accept_c) begin
          x_q   <= in_data;
          n_q   <= key_n;
          r2_q  <= key_r2;
          exp_q <= (in_mode == MODE_DEC) ? key_d : key_e;
          err_q <= reject_c;
          idx_q <= IDX_W'(E_BIT - 1);
        end
        PRE_X: begin
          if (err_q) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_data  <= '0;
          end else if (mm_done) begin
            xm_q <= mm_r;
          end
        end
        PRE_A: if (mm_done) acc_q <= mm_r;
        SQR: if (mm_done) begin
          acc_q <= mm_r;
          if (!exp_q[idx_q] && !last_c) idx_q <= idx_q - IDX_W'(1);
        end
        MUL: if (mm_done) begin
          acc_q <= mm_r;
          if (!last_c) idx_q <= idx_q - IDX_W'(1);
        end
        POST: if (mm_done) begin
          out_data  <= mm_r;
          out_valid <= 1'b1;
          out_err   <= 1'b0;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter N_BIT, default 12: modulus/data width in bits; Montgomery radix R = 2^N_BIT.
REQ-002 SHALL have parameter E_BIT, default 12: exponent width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port in_data, input, N_BIT bits: plaintext or ciphertext x.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 = encrypt (uses key_e), 1 = decrypt (uses key_d).
REQ-009 SHALL have port key_n, input, N_BIT bits: modulus n.
REQ-010 SHALL have ports key_e and key_d, inputs, E_BIT bits each: public and private exponents.
REQ-011 SHALL have port key_r2, input, N_BIT bits: R^2 mod n.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port out_data, output, N_BIT bits: x^exp mod n.
REQ-015 SHALL have port out_err, output, 1 bit: the request was rejected; qualified by out_valid.
REQ-016 SHALL have port busy, output, 1 bit: high from accept until the result is handed off.

Function
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both 1; at that edge SHALL latch in_data, in_mode, key_n, the selected exponent and key_r2; later input changes SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in IDLE with out_valid = 0.
REQ-019 SHALL reject the request when key_n is even, key_n < 3, or in_data >= key_n: out_valid = 1 and out_err = 1 with out_data = 0 exactly 1 cycle after accept, and SHALL perform no computation.
REQ-020 FSM states: IDLE, PRE_X, PRE_A, SQR, MUL, POST, HOLD.
REQ-021 PRE_X SHALL compute xm = MM(x, key_r2). PRE_A SHALL compute A = MM(1, key_r2).
REQ-022 The SQR/MUL loop SHALL scan exponent bits from E_BIT-1 down to 0: SQR computes A = MM(A, A); if the bit is 1, MUL computes A = MM(A, xm); otherwise the FSM advances directly.
REQ-023 POST SHALL compute out_data = MM(A, 1) and then enter HOLD.
REQ-024 MM(a, b) = a·b·R^-1 mod n, fully reduced to a value < n.
REQ-025 Leading zero exponent bits SHALL NOT be skipped (constant iteration count).
REQ-026 Each MM operation SHALL cost exactly M = N_BIT+2 cycles, including the issue cycle.
REQ-027 Valid-request latency from the accept edge to out_valid SHALL be exactly (3 + E_BIT + popcount(exp))·M cycles.
REQ-028 Exponent 0 SHALL yield out_data = 1.
REQ-029 In HOLD, out_valid, out_data and out_err SHALL stay stable until out_ready = 1; the FSM SHALL return to IDLE on the handoff edge, and in_ready rises the next cycle.
REQ-030 out_valid = 1 with out_ready = 1 on the same cycle SHALL complete the handoff in 1 cycle.
REQ-031 Intermediate arithmetic SHALL be N_BIT+2 bits wide with no overflow for any n < R.

Reset
REQ-032 rst = 1 SHALL force, at the next edge: state = IDLE, in_ready = 1 (once rst is low), out_valid = 0, out_err = 0, out_data = 0, busy = 0, and all internal registers to 0.
REQ-033 rst asserted mid-operation SHALL discard the in-flight request with no out_valid pulse.
REQ-034 rst SHALL have priority over every handshake on the same edge.

Structure
REQ-035 Shared package rsa_pkg SHALL hold: the FSM state enum, default N_BIT/E_BIT constants, and mode encodings (MODE_ENC = 0, MODE_DEC = 1).
REQ-036 The design SHALL use one sub-module, mont_mul: radix-2 bit-serial Montgomery multiplier.
REQ-037 mont_mul SHALL be parameterised by N_BIT with ports start, a, b, n, done, r.
REQ-038 mont_mul SHALL use N_BIT iteration cycles plus 1 conditional-subtract cycle, and done SHALL pulse N_BIT+1 cycles after start.
REQ-039 The controller SHALL instantiate exactly one mont_mul, time-shared across all phases.

Verification
REQ-040 Encrypt: N_BIT = 12, E_BIT = 12, key_n = 3551, key_r2 = 2292, key_e = 5, x = 2 -> out_data = 32, out_err = 0, latency (3+12+2)·14 = 238 cycles.
REQ-041 Round trip: decrypt 32 with key_d = 1373 -> 2; also cover x = 0 -> 0 and x = 3550 -> 3550 in both modes.
REQ-042 Exponent zero: key_e = 0, x = 1234 -> out_data = 1, latency 15·14 = 210 cycles.
REQ-043 Rejects: in_data = 3551, then key_n = 3550 -> out_err = 1, out_data = 0, out_valid 1 cycle after accept.
REQ-044 Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_data stable, in_ready = 0, and a second in_valid is not accepted.
REQ-045 Reset: assert rst 100 cycles into an encrypt -> no out_valid, in_ready = 1 the cycle after rst deasserts, and the next request completes correctly.
